// File: rtl/wb_spi_pkg.sv
// Shared constants for the Wishbone SPI register block: register map,
// field positions and reset values.
package wb_spi_pkg;

    localparam logic [2:0] SPCR_A = 3'd0;
    localparam logic [2:0] SPSR_A = 3'd1;
    localparam logic [2:0] SPDR_A = 3'd2;
    localparam logic [2:0] SPER_A = 3'd3;

    localparam int SPCR_SPIE = 7;
    localparam int SPCR_SPE  = 6;
    localparam int SPCR_MSTR = 4;
    localparam int SPCR_CPOL = 3;
    localparam int SPCR_CPHA = 2;

    localparam int SPSR_SPIF = 7;
    localparam int SPSR_WCOL = 6;

    localparam logic [7:0] SPCR_RST = 8'h10;
    localparam logic [7:0] SPSR_RST = 8'h05;
    localparam logic [7:0] SPER_RST = 8'h00;

    typedef struct packed {
        logic       spie;
        logic       spe;
        logic       rsvd;
        logic       mstr;
        logic       cpol;
        logic       cpha;
        logic [1:0] spr;
    } spcr_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Small byte FIFO with synchronous flush; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module spi_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_spi_slave_regs.sv
// Wishbone classic register block for the SPI controller: SPCR/SPSR/SPDR/SPER,
// TX/RX byte FIFOs and the transfer-complete interrupt.
module wb_spi_slave_regs
    import wb_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [2:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       inta_o,
    output logic       spe_o,
    output logic       cpol_o,
    output logic       cpha_o,
    output logic [3:0] spr_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i
);
    logic       acc, wr, rd;
    spcr_t      spcr, spcr_nxt;
    logic       spif, spif_nxt, wcol, wcol_nxt;
    logic [1:0] icnt, icnt_nxt, espr, espr_nxt, cnt, cnt_nxt;
    logic       flush;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head, rd_data;

    // The ~ack_o term keeps a held cyc/stb from starting a second access.
    assign acc = cyc_i & stb_i & ~ack_o;
    assign wr  = acc & we_i;
    assign rd  = acc & ~we_i;

    assign tx_valid_o = ~tx_empty & spcr.spe;
    assign tx_pop     = tx_valid_o & tx_ready_i;
    assign tx_push    = wr & (adr_i == SPDR_A);
    assign rx_push    = rx_valid_i & spcr.spe;
    assign rx_pop     = rd & (adr_i == SPDR_A);
    assign flush      = wr & (adr_i == SPCR_A) & spcr.spe & ~dat_i[SPCR_SPE];

    assign spe_o  = spcr.spe;
    assign cpol_o = spcr.cpol;
    assign cpha_o = spcr.cpha;
    assign spr_o  = {espr, spcr.spr};

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .flush(flush), .push(tx_push), .pop(tx_pop),
        .din(dat_i), .dout(tx_data_o), .full(tx_full), .empty(tx_empty)
    );

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .flush(flush), .push(rx_push), .pop(rx_pop),
        .din(rx_data_i), .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        spcr_nxt = spcr;
        spif_nxt = spif;
        wcol_nxt = wcol;
        icnt_nxt = icnt;
        espr_nxt = espr;
        cnt_nxt  = cnt;
        if (wr) begin
            case (adr_i)
                SPCR_A: begin
                    spcr_nxt      = spcr_t'(dat_i);
                    spcr_nxt.rsvd = 1'b0;
                end
                SPSR_A: begin
                    if (dat_i[SPSR_SPIF]) spif_nxt = 1'b0;
                    if (dat_i[SPSR_WCOL]) wcol_nxt = 1'b0;
                end
                SPER_A: begin
                    icnt_nxt = dat_i[7:6];
                    espr_nxt = dat_i[1:0];
                end
                default: ;
            endcase
        end
        if (tx_push & tx_full & ~tx_pop) wcol_nxt = 1'b1;
        // Bytes dropped on RX overflow still count toward SPIF; a set beats a clear.
        if (flush) begin
            cnt_nxt = 2'd0;
        end else if (rx_push) begin
            if (cnt == icnt) begin
                cnt_nxt  = 2'd0;
                spif_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 2'd1;
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (adr_i)
            SPCR_A:  rd_data = spcr;
            SPSR_A:  rd_data = {spif, wcol, 2'b00, tx_full, tx_empty, rx_full, rx_empty};
            SPDR_A:  rd_data = rx_empty ? 8'h00 : rx_head;
            SPER_A:  rd_data = {icnt, 4'b0000, espr};
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            spcr   <= spcr_t'(SPCR_RST);
            spif   <= SPSR_RST[SPSR_SPIF];
            wcol   <= SPSR_RST[SPSR_WCOL];
            icnt   <= SPER_RST[7:6];
            espr   <= SPER_RST[1:0];
            cnt    <= 2'd0;
            ack_o  <= 1'b0;
            inta_o <= 1'b0;
            dat_o  <= 8'h00;
        end else begin
            spcr   <= spcr_nxt;
            spif   <= spif_nxt;
            wcol   <= wcol_nxt;
            icnt   <= icnt_nxt;
            espr   <= espr_nxt;
            cnt    <= cnt_nxt;
            ack_o  <= acc;
            inta_o <= spcr_nxt.spie & spif_nxt;
            if (rd) dat_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_wb_spi_slave_regs.sv
// Self-checking bench for wb_spi_slave_regs: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based register model.
module tb_wb_spi_slave_regs;
    localparam int DEPTH = 4;

    localparam int K_WR   = 0;
    localparam int K_RD   = 1;
    localparam int K_RX   = 2;
    localparam int K_INTA = 3;
    localparam int K_TXD  = 4;

    typedef struct {
        int         kind;
        logic [2:0] adr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [2:0] adr_i = 3'd0;
    logic [7:0] dat_i = 8'h00;
    logic [7:0] dat_o;
    logic       ack_o, inta_o, spe_o, cpol_o, cpha_o, tx_valid_o;
    logic [3:0] spr_o;
    logic [7:0] tx_data_o;
    logic       tx_ready_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_valid_i = 1'b0;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];

    logic [7:0] m_spcr, m_sper;
    logic       m_spif, m_wcol;
    int         m_cnt;
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];

    always #5 clk_i = ~clk_i;

    wb_spi_slave_regs #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .inta_o(inta_o),
        .spe_o(spe_o), .cpol_o(cpol_o), .cpha_o(cpha_o), .spr_o(spr_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i)
    );

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    // One Wishbone access; starts and ends on a falling edge.
    task automatic apply_stimulus(input logic write, input logic [2:0] adr, input logic [7:0] data,
                                  output logic [7:0] rdata);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = write; adr_i = adr; dat_i = data;
        @(negedge clk_i);
        check_output("ack_high", {7'b0, ack_o}, 8'h01);
        rdata = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
        check_output("ack_low", {7'b0, ack_o}, 8'h00);
    endtask

    task automatic wb_write(input logic [2:0] adr, input logic [7:0] data);
        logic [7:0] unused_rd;
        apply_stimulus(1'b1, adr, data, unused_rd);
    endtask

    task automatic wb_read(input logic [2:0] adr, input logic [7:0] expected, input string name);
        logic [7:0] rd;
        apply_stimulus(1'b0, adr, 8'h00, rd);
        check_output(name, rd, expected);
    endtask

    task automatic rx_pulse(input logic [7:0] data);
        rx_data_i = data; rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic tx_pop_cycle();
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        tx_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; rx_valid_i = 1'b0; tx_ready_i = 1'b0;
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    function automatic logic [7:0] m_spsr();
        return {m_spif, m_wcol, 2'b00, m_tx.size() == DEPTH, m_tx.size() == 0,
                m_rx.size() == DEPTH, m_rx.size() == 0};
    endfunction

    task automatic check_model_outputs();
        logic exp_valid;
        exp_valid = m_spcr[6] && (m_tx.size() > 0);
        check_output("rnd_tx_valid", {7'b0, tx_valid_o}, {7'b0, exp_valid});
        check_output("rnd_inta", {7'b0, inta_o}, {7'b0, m_spcr[7] & m_spif});
        check_output("rnd_spe", {7'b0, spe_o}, {7'b0, m_spcr[6]});
        check_output("rnd_spr", {4'b0, spr_o}, {4'b0, m_sper[1:0], m_spcr[1:0]});
        if (exp_valid) check_output("rnd_tx_data", tx_data_o, m_tx[0]);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] d, exp;
        int op, a;

        for (int i = 0; i < 8; i++)
            vecs.push_back('{K_RD, 3'(i), 8'h00, (i == 0) ? 8'h10 : (i == 1) ? 8'h05 : 8'h00});
        vecs.push_back('{K_WR, 3'd0, 8'h40, 8'h00});
        for (int i = 0; i < 4; i++) vecs.push_back('{K_WR, 3'd2, 8'hA1 + 8'(i), 8'h00});
        vecs.push_back('{K_RD, 3'd1, 8'h00, 8'h09});
        vecs.push_back('{K_WR, 3'd2, 8'hA5, 8'h00});
        vecs.push_back('{K_RD, 3'd1, 8'h00, 8'h49});
        for (int i = 0; i < 4; i++) vecs.push_back('{K_TXD, 3'd0, 8'h00, 8'hA1 + 8'(i)});
        vecs.push_back('{K_RD, 3'd1, 8'h00, 8'h45});
        vecs.push_back('{K_WR, 3'd1, 8'h40, 8'h00});
        vecs.push_back('{K_RD, 3'd1, 8'h00, 8'h05});
        vecs.push_back('{K_WR, 3'd0, 8'hC0, 8'h00});
        vecs.push_back('{K_WR, 3'd3, 8'h40, 8'h00});
        vecs.push_back('{K_RX, 3'd0, 8'h3C, 8'h00});
        vecs.push_back('{K_INTA, 3'd0, 8'h00, 8'h00});
        vecs.push_back('{K_RD, 3'd1, 8'h00, 8'h04});
        vecs.push_back('{K_RX, 3'd0, 8'hC3, 8'h00});
        vecs.push_back('{K_INTA, 3'd0, 8'h00, 8'h01});
        vecs.push_back('{K_RD, 3'd1, 8'h00, 8'h84});
        vecs.push_back('{K_RD, 3'd2, 8'h00, 8'h3C});
        vecs.push_back('{K_RD, 3'd2, 8'h00, 8'hC3});
        vecs.push_back('{K_RD, 3'd2, 8'h00, 8'h00});
        vecs.push_back('{K_WR, 3'd1, 8'h80, 8'h00});
        vecs.push_back('{K_INTA, 3'd0, 8'h00, 8'h00});
        vecs.push_back('{K_RD, 3'd1, 8'h00, 8'h05});
        vecs.push_back('{K_RD, 3'd3, 8'h00, 8'h40});
        vecs.push_back('{K_RD, 3'd0, 8'h00, 8'hC0});

        @(negedge clk_i);
        do_reset();
        check_output("rst_ack", {7'b0, ack_o}, 8'h00);
        check_output("rst_inta", {7'b0, inta_o}, 8'h00);
        check_output("rst_dat", dat_o, 8'h00);
        check_output("rst_tx_valid", {7'b0, tx_valid_o}, 8'h00);
        check_output("rst_cfg", {4'b0, spe_o, cpol_o, cpha_o, 1'b0}, 8'h00);
        check_output("rst_spr", {4'b0, spr_o}, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].kind)
                K_WR: wb_write(vecs[i].adr, vecs[i].dat);
                K_RD: wb_read(vecs[i].adr, vecs[i].exp, $sformatf("vec%0d_rd_adr%0d", i, vecs[i].adr));
                K_RX: rx_pulse(vecs[i].dat);
                K_INTA: begin
                    @(negedge clk_i);
                    check_output($sformatf("vec%0d_inta", i), {7'b0, inta_o}, vecs[i].exp);
                end
                K_TXD: begin
                    check_output($sformatf("vec%0d_tx_valid", i), {7'b0, tx_valid_o}, 8'h01);
                    check_output($sformatf("vec%0d_tx_data", i), tx_data_o, vecs[i].exp);
                    tx_pop_cycle();
                end
                default: ;
            endcase
        end

        wb_write(3'd3, 8'h40);
        check_output("dat_hold", dat_o, 8'hC0);

        // cyc/stb held through the ack cycle must push only one byte
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 3'd2; dat_i = 8'h77;
        @(negedge clk_i);
        check_output("held_ack_high", {7'b0, ack_o}, 8'h01);
        @(negedge clk_i);
        check_output("held_ack_low", {7'b0, ack_o}, 8'h00);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
        check_output("held_tx_data", tx_data_o, 8'h77);
        tx_pop_cycle();
        check_output("held_single_push", {7'b0, tx_valid_o}, 8'h00);

        wb_write(3'd3, 8'h00);
        for (int i = 0; i < 6; i++) rx_pulse(8'h10 + 8'(i));
        wb_read(3'd1, 8'h86, "rx_overflow_spsr");
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd2;
        rx_data_i = 8'h16; rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        check_output("popush_ack", {7'b0, ack_o}, 8'h01);
        check_output("popush_dat", dat_o, 8'h10);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk_i);
        wb_read(3'd1, 8'h86, "popush_spsr");
        wb_read(3'd2, 8'h11, "rx_keep1");
        wb_read(3'd2, 8'h12, "rx_keep2");
        wb_read(3'd2, 8'h13, "rx_keep3");
        wb_read(3'd2, 8'h16, "rx_keep_popush");
        wb_read(3'd2, 8'h00, "rx_empty_read");

        for (int i = 0; i < 4; i++) wb_write(3'd2, 8'hB0 + 8'(i));
        wb_read(3'd1, 8'h89, "tx_full_spsr");
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 3'd2; dat_i = 8'hB4; tx_ready_i = 1'b1;
        @(negedge clk_i);
        tx_ready_i = 1'b0;
        check_output("txfull_push_ack", {7'b0, ack_o}, 8'h01);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
        wb_read(3'd1, 8'h89, "txfull_push_no_wcol");
        check_output("txfull_push_head", tx_data_o, 8'hB1);

        rx_pulse(8'h55);
        wb_write(3'd1, 8'h80);
        wb_read(3'd1, 8'h08, "pre_flush_spsr");
        wb_write(3'd0, 8'h00);
        check_output("flush_tx_valid", {7'b0, tx_valid_o}, 8'h00);
        check_output("flush_spe", {7'b0, spe_o}, 8'h00);
        wb_read(3'd1, 8'h05, "flush_spsr");
        rx_pulse(8'h66);
        wb_read(3'd1, 8'h05, "rx_ignored_spe0");

        wb_write(3'd0, 8'h4F);
        wb_write(3'd3, 8'h03);
        check_output("cfg_spr", {4'b0, spr_o}, 8'h0F);
        check_output("cfg_cpol_cpha", {6'b0, cpol_o, cpha_o}, 8'h03);
        wb_read(3'd0, 8'h4F, "spcr_readback");
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd3;
        @(posedge clk_i);
        #1;
        check_output("midrst_ack_high", {7'b0, ack_o}, 8'h01);
        rst_i = 1'b0;
        #1;
        check_output("midrst_ack_drop", {7'b0, ack_o}, 8'h00);
        check_output("midrst_spr", {4'b0, spr_o}, 8'h00);
        check_output("midrst_cfg", {5'b0, spe_o, cpol_o, cpha_o}, 8'h00);
        check_output("midrst_dat", dat_o, 8'h00);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        wb_read(3'd0, 8'h10, "midrst_spcr");
        wb_read(3'd1, 8'h05, "midrst_spsr");
        wb_read(3'd3, 8'h00, "midrst_sper");

        do_reset();
        m_spcr = 8'h10; m_sper = 8'h00; m_spif = 1'b0; m_wcol = 1'b0; m_cnt = 0;
        m_tx.delete(); m_rx.delete();
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 8);
            d  = 8'($urandom);
            case (op)
                0: begin
                    if ($urandom_range(0, 3) != 0) d[6] = 1'b1;
                    wb_write(3'd0, d);
                    if (m_spcr[6] && !d[6]) begin
                        m_tx.delete(); m_rx.delete(); m_cnt = 0;
                    end
                    m_spcr = d & 8'hDF;
                end
                1: begin
                    wb_write(3'd2, d);
                    if (m_tx.size() == DEPTH) m_wcol = 1'b1;
                    else m_tx.push_back(d);
                end
                2: begin
                    exp = (m_rx.size() > 0) ? m_rx.pop_front() : 8'h00;
                    wb_read(3'd2, exp, "rnd_spdr");
                end
                3: begin
                    rx_pulse(d);
                    if (m_spcr[6]) begin
                        if (m_rx.size() < DEPTH) m_rx.push_back(d);
                        m_cnt = m_cnt + 1;
                        if (m_cnt == int'(m_sper[7:6]) + 1) begin
                            m_spif = 1'b1;
                            m_cnt  = 0;
                        end else begin
                            m_cnt = m_cnt % 4;
                        end
                    end
                end
                4: begin
                    tx_pop_cycle();
                    if (m_spcr[6] && m_tx.size() > 0) void'(m_tx.pop_front());
                end
                5: wb_read(3'd1, m_spsr(), "rnd_spsr");
                6: begin
                    wb_write(3'd1, d);
                    if (d[7]) m_spif = 1'b0;
                    if (d[6]) m_wcol = 1'b0;
                end
                7: begin
                    wb_write(3'd3, d);
                    m_sper = d & 8'hC3;
                end
                default: begin
                    a = $urandom_range(0, 5);
                    if (a == 0)      wb_read(3'd0, m_spcr, "rnd_spcr");
                    else if (a == 1) wb_read(3'd3, m_sper, "rnd_sper");
                    else             wb_read(3'(a + 2), 8'h00, "rnd_unmapped");
                end
            endcase
            @(negedge clk_i);
            check_model_outputs();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
